duty_ramp: RTL and testbench

DUTY_RAMP -- requirements
Module: duty_ramp

---
 rtl/duty_ramp_pkg.sv | 16 +
 rtl/period_timer.sv | 32 +++
 rtl/duty_ramp.sv | 127 ++++++++++++
 tb/tb_duty_ramp.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/duty_ramp_pkg.sv
// duty_ramp_pkg -- shared definitions for the duty-cycle ramp controller.
//   IDLE/UP/DOWN : state encodings used by the ramp FSM
//   state_t      : enumerated state type built on those encodings
package duty_ramp_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_UP   = UP,
    ST_DOWN = DOWN
  } state_t;

endpackage

// File: rtl/period_timer.sv
// period_timer -- free-running PWM period counter.
//   clk          : rising-edge clock
//   reset        : synchronous, active-high
//   period_tick  : high while the counter is all-ones (the next edge wraps to 0)
//   period_start : registered, high while the counter equals 0
module period_timer
  import duty_ramp_pkg::*;
#(
  parameter int CTR_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  output logic period_tick,
  output logic period_start
);

  logic [CTR_LEN-1:0] counter;

  assign period_tick = &counter;

  // period_start is the tick delayed one edge, so it lines up with counter == 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter      <= '0;
      period_start <= 1'b0;
    end else begin
      counter      <= counter + 1'b1;
      period_start <= period_tick;
    end
  end

endmodule

// File: rtl/duty_ramp.sv
// duty_ramp -- ramps a PWM compare value toward a requested target in
// saturating steps, one step every (step_div+1) PWM periods.
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   target        : requested final duty value
//   step_size     : duty increment per step (0 behaves as 1)
//   step_div      : extra PWM periods between steps
//   target_valid  : request strobe; target_ready : request accepted when both high
//   compare       : registered duty value for the downstream pwm
//   period_start  : registered pulse while the period counter is 0
//   busy          : ramp in progress (UP or DOWN)
//   done          : registered one-cycle pulse when a ramp completes
//
// state   | meaning
// IDLE    | waiting for a request; compare holds
// UP      | stepping compare upward toward target_l
// DOWN    | stepping compare downward toward target_l
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int CTR_LEN = 8,
  parameter int DIV_LEN = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CTR_LEN-1:0] target,
  input  logic [CTR_LEN-1:0] step_size,
  input  logic [DIV_LEN-1:0] step_div,
  input  logic               target_valid,
  output logic               target_ready,
  output logic [CTR_LEN-1:0] compare,
  output logic               period_start,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic [CTR_LEN-1:0] target_l;
  logic [CTR_LEN-1:0] step_l;
  logic [DIV_LEN-1:0] step_div_l;
  logic [DIV_LEN-1:0] div_cnt;
  logic               period_tick;

  logic [CTR_LEN:0]   up_sum;
  logic [CTR_LEN:0]   down_diff;
  logic [CTR_LEN-1:0] up_next;
  logic [CTR_LEN-1:0] down_next;

  period_timer #(.CTR_LEN(CTR_LEN)) u_period_timer (
    .clk          (clk),
    .reset        (reset),
    .period_tick  (period_tick),
    .period_start (period_start)
  );

  assign target_ready = (state == ST_IDLE) && !reset;
  assign busy         = (state == ST_UP) || (state == ST_DOWN);

  // One extra bit catches carry/borrow so the result clamps instead of wrapping.
  always_comb begin
    up_sum    = {1'b0, compare} + {1'b0, step_l};
    down_diff = {1'b0, compare} - {1'b0, step_l};
    up_next   = compare;
    down_next = compare;
    if (up_sum > {1'b0, target_l}) up_next = target_l;
    else                           up_next = up_sum[CTR_LEN-1:0];
    if (down_diff[CTR_LEN] || (down_diff[CTR_LEN-1:0] < target_l)) down_next = target_l;
    else                                                           down_next = down_diff[CTR_LEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      compare    <= '0;
      target_l   <= '0;
      step_l     <= '0;
      step_div_l <= '0;
      div_cnt    <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (target_valid) begin
            target_l   <= target;
            step_l     <= (step_size == '0) ? {{(CTR_LEN-1){1'b0}}, 1'b1} : step_size;
            step_div_l <= step_div;
            div_cnt    <= '0;
            if (target > compare)      state <= ST_UP;
            else if (target < compare) state <= ST_DOWN;
            else                       done  <= 1'b1;
          end
        end
        ST_UP: begin
          // Steps land only on the wrap edge so each PWM period sees one duty value.
          if (period_tick) begin
            if (div_cnt == step_div_l) begin
              div_cnt <= '0;
              compare <= up_next;
              if (up_next == target_l) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        ST_DOWN: begin
          if (period_tick) begin
            if (div_cnt == step_div_l) begin
              div_cnt <= '0;
              compare <= down_next;
              if (down_next == target_l) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// tb_duty_ramp -- directed self-checking bench for duty_ramp (CTR_LEN=8).
module tb_duty_ramp;

  localparam int CTR_LEN = 8;
  localparam int DIV_LEN = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [CTR_LEN-1:0] target;
  logic [CTR_LEN-1:0] step_size;
  logic [DIV_LEN-1:0] step_div;
  logic               target_valid;
  logic               target_ready;
  logic [CTR_LEN-1:0] compare;
  logic               period_start;
  logic               busy;
  logic               done;

  int errs = 0;
  int checks = 0;
  int done_cnt = 0;
  int n;

  duty_ramp #(.CTR_LEN(CTR_LEN), .DIV_LEN(DIV_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .target       (target),
    .step_size    (step_size),
    .step_div     (step_div),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .compare      (compare),
    .period_start (period_start),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Counts each cycle done was high, tallied at the closing edge of that cycle.
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ps(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (period_start !== 1'b1 && cnt < 300);
  endtask

  task automatic request(input int t, input int s, input int d);
    target       = CTR_LEN'(t);
    step_size    = CTR_LEN'(s);
    step_div     = DIV_LEN'(d);
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  logic [CTR_LEN-1:0] sat_exp [3];

  initial begin
    reset        = 1'b1;
    target       = '0;
    step_size    = '0;
    step_div     = '0;
    target_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_compare", 32'(compare), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_period_start", 32'(period_start), 0);
    chk("rst_ready", 32'(target_ready), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(target_ready), 1);

    wait_ps(n);
    chk("first_period_len", 32'(n), 256);
    wait_ps(n);
    chk("second_period_len", 32'(n), 256);
    chk("idle_compare", 32'(compare), 0);

    // Ramp up 0 -> 100 in steps of 10, one step per period.
    request(100, 10, 0);
    chk("up_busy", 32'(busy), 1);
    chk("up_ready", 32'(target_ready), 0);
    chk("up_compare0", 32'(compare), 0);
    for (int k = 1; k <= 10; k++) begin
      wait_ps(n);
      chk("up_period_len", 32'(n), (k == 1) ? 255 : 256);
      chk("up_compare", 32'(compare), 32'(10 * k));
      chk("up_done", 32'(done), (k == 10) ? 1 : 0);
      chk("up_busy_run", 32'(busy), (k == 10) ? 0 : 1);
    end

    // Saturating ramp up, request presented in the done cycle.
    sat_exp[0] = 8'd160;
    sat_exp[1] = 8'd220;
    sat_exp[2] = 8'd255;
    request(255, 60, 0);
    chk("sat_busy", 32'(busy), 1);
    for (int k = 0; k < 3; k++) begin
      wait_ps(n);
      chk("sat_compare", 32'(compare), 32'(sat_exp[k]));
      chk("sat_done", 32'(done), (k == 2) ? 1 : 0);
    end

    // Oversized downward step clamps at target.
    request(20, 255, 0);
    wait_ps(n);
    chk("down20_compare", 32'(compare), 20);
    chk("down20_done", 32'(done), 1);

    // Ramp down 20 -> 0 in steps of 7.
    request(0, 7, 0);
    for (int k = 1; k <= 3; k++) begin
      wait_ps(n);
      chk("down_compare", 32'(compare), (k == 3) ? 0 : 32'(20 - 7 * k));
      chk("down_busy", 32'(busy), (k == 3) ? 0 : 1);
      chk("down_done", 32'(done), (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk("down_done_single", 32'(done), 0);
    chk("done_count_a", 32'(done_cnt), 4);

    // step_size 0 behaves as 1, one step every 3 periods; busy-time request ignored.
    request(3, 0, 2);
    for (int k = 1; k <= 9; k++) begin
      wait_ps(n);
      chk("div_period_len", 32'(n), (k == 1) ? 254 : 256);
      chk("div_compare", 32'(compare), 32'(k / 3));
      chk("div_done", 32'(done), (k == 9) ? 1 : 0);
      if (k == 1) begin
        target       = 8'd200;
        step_size    = 8'd50;
        step_div     = 16'd0;
        target_valid = 1'b1;
        chk("div_ready_busy", 32'(target_ready), 0);
      end
      if (k == 2) target_valid = 1'b0;
    end
    @(negedge clk);
    chk("div_not_queued", 32'(busy), 0);
    chk("div_final", 32'(compare), 3);
    chk("done_count_b", 32'(done_cnt), 5);

    // target equal to compare: done next cycle, compare untouched.
    request(3, 5, 0);
    chk("eq_done", 32'(done), 1);
    chk("eq_compare", 32'(compare), 3);
    chk("eq_busy", 32'(busy), 0);
    @(negedge clk);
    chk("eq_done_single", 32'(done), 0);
    chk("done_count_c", 32'(done_cnt), 6);

    // Reset in the middle of a ramp at compare=50 aborts silently.
    request(100, 47, 0);
    wait_ps(n);
    chk("abort_compare_pre", 32'(compare), 50);
    chk("abort_busy_pre", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_compare", 32'(compare), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_done", 32'(done), 0);
    chk("abort_ready", 32'(target_ready), 1);
    chk("done_count_d", 32'(done_cnt), 6);
    wait_ps(n);
    chk("abort_period_len", 32'(n), 255);
    chk("abort_compare_hold", 32'(compare), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
